// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
//
// Purpose:
//   32-entry general-purpose register file for the single-cycle MIPS datapath.
//   One synchronous write port (writeback path) and two asynchronous read
//   ports (ALU operand A, and input "a" of the ALU-operand select mux).
//   Register 0 is hardwired to zero on both read ports.
//
// Parameters:
//   DATA_W  register width in bits            (default 32)
//   ADDR_W  register address width            (default 5, depth = 2**ADDR_W)
//
// Ports:
//   clk   in   1       system clock, all state updates on the rising edge
//   rst   in   1       synchronous active-high reset, clears every entry
//   ra1   in   ADDR_W  read address, port 1 (rs field)
//   ra2   in   ADDR_W  read address, port 2 (rt field)
//   rd1   out  DATA_W  read data, port 1 (ALU operand A)
//   rd2   out  DATA_W  read data, port 2 (operand mux input a)
//   we    in   1       write enable
//   wa    in   ADDR_W  write address (after RegDst selection)
//   wd    in   DATA_W  write data (after MemtoReg selection)
//
// Handshake:
//   There is no valid/ready pair. A write is presented for one cycle with
//   we=1 and is always accepted on the next rising edge; reads are
//   combinational and always valid for the current ra1/ra2.
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a write in progress (we=1, rst=0,
//                      wa!=0) is forwarded combinationally to any read port
//                      whose address matches wa. When undefined, a
//                      same-address read returns the stored (old) value
//                      until the rising edge.
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage array. Entry 0 is cleared on reset and never written, but the
  // read path masks it anyway so register 0 reads zero in every situation.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // A write takes effect only when enabled, not in reset, and not aimed at
  // register 0 (writes to register 0 are silently dropped).
  logic wr_fire_d;

  // Raw array reads before the register-0 mask and any forwarding.
  logic [DATA_W-1:0] arr_rd1;
  logic [DATA_W-1:0] arr_rd2;

  assign wr_fire_d = we && !rst && (wa != '0);

  // ---------------------------------------------------------------------------
  // Write port / synchronous reset. Reset dominates the write enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire_d) begin
      mem_q[wa] <= wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: combinational, zero latency.
  // ---------------------------------------------------------------------------
  assign arr_rd1 = mem_q[ra1];
  assign arr_rd2 = mem_q[ra2];

  always_comb begin
    rd1 = '0;
    rd2 = '0;

    if (ra1 != '0) begin
      rd1 = arr_rd1;
    end
    if (ra2 != '0) begin
      rd2 = arr_rd2;
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the value being written so a reader in the same cycle sees it
    // before the edge. wr_fire_d already excludes reset and register 0, so
    // register 0 is never forwarded.
    if (wr_fire_d && (wa == ra1)) begin
      rd1 = wd;
    end
    if (wr_fire_d && (wa == ra2)) begin
      rd2 = wd;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2r1w
//
// Self-checking bench for reg_file_2r1w. A behavioural array model is updated
// on every rising edge; one compare process checks rd1/rd2 on every falling
// edge once the first reset has been seen. Directed sections add literal
// expectations that pin the model, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_reg_file_2r1w;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_2r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ra1(ra1),
    .ra2(ra2),
    .rd1(rd1),
    .rd2(rd2),
    .we (we),
    .wa (wa),
    .wd (wd)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: plain array of register contents.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_init = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_init = 1;
    end else if (we && wa != 0) begin
      model_mem[wa] = wd;
    end
  end

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && wa != 0 && wa == a) return wd;
`endif
    return model_mem[a];
  endfunction

  // Compare process: every falling edge after the first reset.
  always @(negedge clk) begin
    if (model_init) begin
      check("model_rd1", rd1, model_read(ra1));
      check("model_rd2", rd2, model_read(ra2));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Move to just after the next rising edge; inputs change only here.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input int a1, input int a2);
    ra1 = ADDR_W'(a1);
    ra2 = ADDR_W'(a2);
  endtask

  task automatic set_write(input bit en, input int a, input logic [DATA_W-1:0] d);
    we = en;
    wa = ADDR_W'(a);
    wd = d;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] exp_rdw;

  initial begin
    rst = 1'b1;
    set_write(0, 0, '0);
    set_read(0, 0);

    // Reset for one cycle, then sweep all addresses.
    edge_step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_read(i, DEPTH - 1 - i);
      @(negedge clk);
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
      edge_step();
    end

    // Basic write then read, then hold with we=0.
    set_write(1, 5, 32'hDEADBEEF);
    set_read(0, 0);
    edge_step();
    set_write(0, 5, 32'h1);
    set_read(5, 5);
    @(negedge clk);
    check("wr5_rd1", rd1, 32'hDEADBEEF);
    check("wr5_rd2", rd2, 32'hDEADBEEF);
    edge_step();
    @(negedge clk);
    check("hold5_rd1", rd1, 32'hDEADBEEF);
    edge_step();

    // Write to register 0 is dropped.
    set_write(1, 0, 32'hFFFFFFFF);
    set_read(0, 5);
    edge_step();
    set_write(0, 0, '0);
    @(negedge clk);
    check("r0_rd1", rd1, 32'h0);
    check("r0_keep5", rd2, 32'hDEADBEEF);
    edge_step();

    // Same-address read during write.
    set_write(1, 7, 32'h11111111);
    edge_step();
    set_write(1, 7, 32'h22222222);
    set_read(0, 7);
`ifdef REGFILE_BYPASS_EN
    exp_rdw = 32'h22222222;
`else
    exp_rdw = 32'h11111111;
`endif
    @(negedge clk);
    check("rdw_before", rd2, exp_rdw);
    edge_step();
    set_write(0, 0, '0);
    @(negedge clk);
    check("rdw_after", rd2, 32'h22222222);
    edge_step();

    // Reset dominates a simultaneous write.
    rst = 1'b1;
    set_write(1, 3, 32'hA5A5A5A5);
    set_read(3, 5);
    edge_step();
    rst = 1'b0;
    set_write(0, 0, '0);
    @(negedge clk);
    check("rstwr_rd1", rd1, 32'h0);
    check("rstwr_rd2", rd2, 32'h0);
    edge_step();

    // Fill 1..31 and read mirrored pairs.
    for (int i = 1; i < DEPTH; i++) begin
      set_write(1, i, 32'h100 + i);
      edge_step();
    end
    set_write(0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      set_read(i, DEPTH - 1 - i);
      @(negedge clk);
      check("fill_rd1", rd1, (i == 0) ? 32'h0 : 32'h100 + i);
      check("fill_rd2", rd2, (i == DEPTH - 1) ? 32'h0 : 32'h100 + (DEPTH - 1 - i));
      edge_step();
    end
    set_read(31, 31);
    @(negedge clk);
    check("same31_rd1", rd1, 32'h11F);
    check("same31_rd2", rd2, 32'h11F);
    edge_step();

    // Randomized phase, checked by the compare process every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_write($urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1), $urandom);
      // Bias reads toward the write address to exercise read-during-write.
      if ($urandom_range(0, 3) == 0) set_read(wa, $urandom_range(0, DEPTH - 1));
      else if ($urandom_range(0, 3) == 0) set_read($urandom_range(0, DEPTH - 1), wa);
      else set_read($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      edge_step();
    end
    rst = 1'b0;
    set_write(0, 0, '0);
    edge_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the 32-bit 2:1 ALU-operand select mux.
  - Read port 2 data is that mux's "a" input, selected when select=0.
  - The sign-extended immediate is its "b" input.
- One synchronous write port, written from the writeback path. Two asynchronous read ports feed the ALU operand path.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width. Depth = 2**ADDR_W = 32 entries.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ra1  input  ADDR_W  read address, port 1 (rs field).
- ra2  input  ADDR_W  read address, port 2 (rt field).
- rd1  output DATA_W  read data, port 1 (ALU operand A).
- rd2  output DATA_W  read data, port 2 (to operand mux input a).
- we   input  1  write enable.
- wa   input  ADDR_W  write address (rd/rt field after RegDst selection).
- wd   input  DATA_W  write data (from MemtoReg selection).

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Storage: array of 2**ADDR_W words of DATA_W bits.
- Reset: on a rising edge with rst=1, all entries are cleared to 0.
  - rst dominates we: no write occurs on that edge.
  - rd1 and rd2 read 0 for every address from the following cycle onward.
  - Reset asserted in the middle of a write sequence discards that write.
  - Contents before the first reset edge are X; the bench does not check them.
- Write: on a rising edge with rst=0, we=1 and wa!=0, mem[wa] <= wd.
  - we=0: no state change.
  - wa=0: the write is silently dropped. No error, no side effect.
- Register 0: hardwired zero.
  - rd1=0 whenever ra1=0, and rd2=0 whenever ra2=0, regardless of any write history.
  - No storage update to entry 0 is ever visible.
- Read: purely combinational from ra1/ra2 and current array contents. Zero latency.
  - rd1 = (ra1==0) ? 0 : mem[ra1]; rd2 likewise for ra2.
- Read-during-write to the same address (base behaviour): the read returns the OLD contents until the edge and the new value after it. The single-cycle datapath relies on a write-then-read-next-cycle ordering.
- Simultaneous reads: ra1==ra2 is legal; both ports return identical data.
- Write while both ports read the written address: both ports update together after the edge.
- No handshake: the write is single-cycle and always accepted.
- No output registers: rd1/rd2 have no reset value of their own. Their value follows the array.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding.
  - If we=1, rst=0, wa!=0 and wa==ra1, then rd1 = wd combinationally in the same cycle, before the edge. Same rule for ra2 and rd2.
  - Address 0 is never forwarded.
  - rst=1 suppresses forwarding.
- Not defined: no forwarding path exists. A same-address read returns the stored (old) value until the rising edge, as in the base behaviour.

Test Plan:
- rst=1 for 1 cycle, then release; sweep ra1 and ra2 over 0..31 -> rd1=rd2=32'h0 for every address.
- we=1, wa=5, wd=32'hDEADBEEF, one edge; then ra1=5, ra2=5 -> rd1=rd2=32'hDEADBEEF. Next cycle we=0, wd=32'h1 -> value unchanged.
- we=1, wa=0, wd=32'hFFFFFFFF, one edge; then ra1=0 -> rd1=32'h0. All other entries unchanged.
- Same-address read-during-write: mem[7]=32'h11111111; drive we=1, wa=7, wd=32'h22222222, ra2=7.
  - Without REGFILE_BYPASS_EN: rd2=32'h11111111 before the edge and 32'h22222222 after.
  - With REGFILE_BYPASS_EN: rd2=32'h22222222 before the edge.
- rst=1 together with we=1, wa=3, wd=32'hA5A5A5A5 on the same edge -> after the edge, ra1=3 gives 32'h0. Previously written entry 5 also reads 32'h0.
- Fill entries 1..31 with value (32'h100 + index), then read pairs (ra1=i, ra2=31-i) -> each port returns its own entry. ra1=ra2=31 returns 32'h11F on both.
